// File: rtl/block_deinterleaver.sv
// Ping-pong block de-interleaver: collects N_ROWS*N_COLS coded bits and streams them out column-major.
// Define DEINT_BYPASS_EN to add the 'bypass' port, which passes bits straight through when the banks are idle.
module block_deinterleaver #(
  parameter int N_ROWS = 6,
  parameter int N_COLS = 8
) (
  input  logic       Clk,
  input  logic       reset,
`ifdef DEINT_BYPASS_EN
  input  logic       bypass,
`endif
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_sof,
  output logic [7:0] frames_out,
  output logic       drop_err
);

  localparam int F  = N_ROWS * N_COLS;
  localparam int PW = $clog2(F);
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [PW-1:0] LAST     = PW'(F - 1);
  localparam logic [PW-1:0] ROW_STEP = PW'(N_ROWS);
  localparam logic [PW-1:0] COL_WRAP = PW'((N_COLS - 1) * N_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        r_state;
  logic [F-1:0]  r_bank [2];
  logic [1:0]    r_full;
  logic          r_wsel;
  logic          r_rsel;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_raddr;
  logic [CW-1:0] r_rcol;
  logic          w_bypass;
  logic          w_accept;
  logic          w_wdone;

`ifdef DEINT_BYPASS_EN
  logic          r_bypass;
  logic [PW-1:0] r_bypCnt;
  assign w_bypass = r_bypass;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready = w_bypass | ~r_full[r_wsel];
  assign w_accept = in_valid & in_ready & ~w_bypass;
  assign w_wdone  = w_accept && (r_wptr == LAST);

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_wsel   <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bank[r_wsel][r_wptr] <= in_bit;
        if (r_wptr == LAST) begin
          r_wptr <= '0;
          r_wsel <= ~r_wsel;
        end else begin
          r_wptr <= r_wptr + 1'b1;
        end
      end
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

  // Read address walks down a column in steps of N_ROWS, then jumps back to the top of the next column.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_full     <= '0;
      r_rsel     <= 1'b0;
      r_rptr     <= '0;
      r_raddr    <= '0;
      r_rcol     <= '0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frames_out <= '0;
`ifdef DEINT_BYPASS_EN
      r_bypass   <= 1'b0;
      r_bypCnt   <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_full[r_rsel]) begin
            r_state <= STREAM;
            r_rptr  <= '0;
            r_raddr <= '0;
            r_rcol  <= '0;
          end
        end
        STREAM: begin
          out_bit   <= r_bank[r_rsel][r_raddr];
          out_valid <= 1'b1;
          out_sof   <= (r_rptr == '0);
          if (r_rptr == LAST) begin
            r_full[r_rsel] <= 1'b0;
            r_rsel         <= ~r_rsel;
            frames_out     <= frames_out + 8'd1;
            r_rptr         <= '0;
            r_raddr        <= '0;
            r_rcol         <= '0;
            // Also chain onto a bank finishing this very edge, so a writer stalled one cycle leaves no output gap.
            if (!r_full[~r_rsel] && !(w_wdone && (r_wsel == ~r_rsel))) r_state <= IDLE;
          end else begin
            r_rptr <= r_rptr + 1'b1;
            if (r_rcol == LAST_COL) begin
              r_rcol  <= '0;
              r_raddr <= r_raddr - COL_WRAP;
            end else begin
              r_rcol  <= r_rcol + 1'b1;
              r_raddr <= r_raddr + ROW_STEP;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_wdone) r_full[r_wsel] <= 1'b1;
`ifdef DEINT_BYPASS_EN
      if (!r_bypass) r_bypCnt <= '0;
      if (r_bypass) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_bit  <= in_bit;
          out_sof  <= (r_bypCnt == '0);
          r_bypCnt <= (r_bypCnt == LAST) ? '0 : r_bypCnt + 1'b1;
        end
      end
      if (r_state == IDLE && r_full == 2'b00 && r_wptr == '0) r_bypass <= bypass;
`endif
    end
  end

endmodule

// File: tb/tb_block_deinterleaver.sv
// Self-checking bench for block_deinterleaver: random frames against a column-major reorder model.
`timescale 1ns/1ps
module tb_block_deinterleaver;
  localparam int N_ROWS = 6;
  localparam int N_COLS = 8;
  localparam int F = N_ROWS * N_COLS;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, out_bit, out_valid, out_sof, drop_err;
  logic [7:0] frames_out;
`ifdef DEINT_BYPASS_EN
  logic bypass = 1'b0;
`endif

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int lastDriveCyc = 0;
  int expFrames = 0;
  logic outQ[$];
  logic sofQ[$];
  int cycQ[$];

  block_deinterleaver #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) dut (
    .Clk(Clk),
    .reset(reset),
`ifdef DEINT_BYPASS_EN
    .bypass(bypass),
`endif
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_bit(out_bit),
    .out_valid(out_valid),
    .out_sof(out_sof),
    .frames_out(frames_out),
    .drop_err(drop_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Capture every valid output bit with its sof flag and the cycle it appeared in.
  always @(negedge Clk) begin
    if (out_valid === 1'b1) begin
      outQ.push_back(out_bit);
      sofQ.push_back(out_sof);
      cycQ.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: output position j carries input position (j mod N_COLS)*N_ROWS + (j div N_COLS).
  function automatic logic [F-1:0] deint(input logic [F-1:0] x);
    logic [F-1:0] y;
    for (int j = 0; j < F; j++) y[j] = x[(j % N_COLS) * N_ROWS + (j / N_COLS)];
    return y;
  endfunction

  function automatic logic [F-1:0] randFrame();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[F-1:0];
  endfunction

  task automatic clearQueues();
    outQ.delete();
    sofQ.delete();
    cycQ.delete();
  endtask

  task automatic doReset();
    @(negedge Clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    clearQueues();
    expFrames = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      in_valid = 1'b0;
    end
  endtask

  // Offers one bit per cycle, pausing whenever the block is not ready; in_valid is left high after the last bit.
  task automatic sendFrame(input logic [F-1:0] f);
    int i = 0;
    int stalls = 0;
    while (i < F && stalls < 200) begin
      @(negedge Clk);
      if (in_ready === 1'b1) begin
        in_bit = f[i];
        in_valid = 1'b1;
        lastDriveCyc = cyc;
        i++;
      end else begin
        in_valid = 1'b0;
        stalls++;
      end
    end
    checks++;
    if (i != F) begin
      fails++;
      $display("[TB] FAIL sendFrame_ready: sent %0d bits, required %0d", i, F);
    end
  endtask

  task automatic waitOut(input int n, input string name);
    int b = 0;
    while (outQ.size() < n && b < 600) begin
      @(negedge Clk);
      in_valid = 1'b0;
      b++;
    end
    checks++;
    if (outQ.size() < n) begin
      fails++;
      $display("[TB] FAIL %s_timeout: got %0d output bits, required %0d", name, outQ.size(), n);
    end
  endtask

  task automatic popFrame(output logic [F-1:0] d, output logic [F-1:0] s, output int c0);
    if (outQ.size() < F) begin
      d = 'x;
      s = 'x;
      c0 = -1;
      return;
    end
    c0 = cycQ[0];
    for (int j = 0; j < F; j++) begin
      d[j] = outQ.pop_front();
      s[j] = sofQ.pop_front();
      void'(cycQ.pop_front());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_sof !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_sof: got %b required 0", out_sof); end
    checks++; if (out_bit !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_bit: got %b required 0", out_bit); end
    checks++; if (frames_out !== 8'd0) begin fails++; $display("[TB] FAIL reset_frames_out: got %0d required 0", frames_out); end
    checks++; if (drop_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_drop_err: got %b required 0", drop_err); end
    reset = 1'b0;
    @(negedge Clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    clearQueues();
  endtask

  task automatic test_onehot();
    int idxs[3] = '{1, 6, 47};
    logic [F-1:0] f, d, s, sofExp;
    int c0;
    sofExp = '0;
    sofExp[0] = 1'b1;
    doReset();
    for (int k = 0; k < 3; k++) begin
      f = '0;
      f[idxs[k]] = 1'b1;
      sendFrame(f);
      idle(1);
      waitOut(F, "onehot");
      popFrame(d, s, c0);
      expFrames++;
      checks++; if (d !== deint(f)) begin fails++; $display("[TB] FAIL onehot%0d_data: got %h required %h", idxs[k], d, deint(f)); end
      checks++; if (s !== sofExp) begin fails++; $display("[TB] FAIL onehot%0d_sof: got %h required %h", idxs[k], s, sofExp); end
      checks++; if (c0 != lastDriveCyc + 3) begin fails++; $display("[TB] FAIL onehot%0d_latency: first bit at cycle %0d required %0d", idxs[k], c0, lastDriveCyc + 3); end
      idle(2);
      checks++; if (frames_out !== expFrames[7:0]) begin fails++; $display("[TB] FAIL onehot%0d_frames_out: got %0d required %0d", idxs[k], frames_out, expFrames); end
    end
  endtask

  task automatic test_back_to_back();
    logic [F-1:0] f [3];
    logic [F-1:0] d, s;
    int c0, span, sofBad;
    doReset();
    for (int k = 0; k < 3; k++) f[k] = randFrame();
    for (int k = 0; k < 3; k++) sendFrame(f[k]);
    idle(1);
    waitOut(3 * F, "b2b");
    span = (cycQ.size() >= 3 * F) ? cycQ[3 * F - 1] - cycQ[0] : -1;
    checks++; if (span != 3 * F - 1) begin fails++; $display("[TB] FAIL b2b_gapless: span %0d cycles required %0d", span, 3 * F - 1); end
    sofBad = 0;
    for (int i = 0; i < 3 * F && i < sofQ.size(); i++)
      if (sofQ[i] !== ((i % F) == 0)) sofBad++;
    checks++; if (sofBad != 0) begin fails++; $display("[TB] FAIL b2b_sof: %0d misplaced sof flags required 0", sofBad); end
    for (int k = 0; k < 3; k++) begin
      popFrame(d, s, c0);
      checks++; if (d !== deint(f[k])) begin fails++; $display("[TB] FAIL b2b_frame%0d_data: got %h required %h", k, d, deint(f[k])); end
    end
    idle(2);
    checks++; if (drop_err !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drop_err: got %b required 0", drop_err); end
    checks++; if (frames_out !== 8'd3) begin fails++; $display("[TB] FAIL b2b_frames_out: got %0d required 3", frames_out); end
  endtask

  task automatic test_overflow();
    logic [F-1:0] f0, f1, d, s;
    int c0;
    doReset();
    f0 = randFrame();
    f1 = randFrame();
    sendFrame(f0);
    sendFrame(f1);
    @(negedge Clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL ovf_in_ready: got %b required 0", in_ready); end
    in_bit = 1'b1;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (drop_err !== 1'b1) begin fails++; $display("[TB] FAIL ovf_drop_err: got %b required 1", drop_err); end
    waitOut(2 * F, "ovf");
    popFrame(d, s, c0);
    checks++; if (d !== deint(f0)) begin fails++; $display("[TB] FAIL ovf_frame0_data: got %h required %h", d, deint(f0)); end
    popFrame(d, s, c0);
    checks++; if (d !== deint(f1)) begin fails++; $display("[TB] FAIL ovf_frame1_data: got %h required %h", d, deint(f1)); end
    idle(5);
    checks++; if (drop_err !== 1'b1) begin fails++; $display("[TB] FAIL ovf_drop_sticky: got %b required 1", drop_err); end
    checks++; if (frames_out !== 8'd2) begin fails++; $display("[TB] FAIL ovf_frames_out: got %0d required 2", frames_out); end
  endtask

  task automatic test_reset_midframe();
    logic [F-1:0] f0, f2, d, s;
    int c0;
    doReset();
    f0 = randFrame();
    sendFrame(f0);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      in_bit = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
    end
    @(negedge Clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge Clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_out_valid: got %b required 0", out_valid); end
    checks++; if (frames_out !== 8'd0) begin fails++; $display("[TB] FAIL midrst_frames_out: got %0d required 0", frames_out); end
    reset = 1'b0;
    @(negedge Clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_ready: got %b required 1", in_ready); end
    clearQueues();
    f2 = randFrame();
    sendFrame(f2);
    idle(1);
    waitOut(F, "midrst");
    popFrame(d, s, c0);
    checks++; if (d !== deint(f2)) begin fails++; $display("[TB] FAIL midrst_fresh_data: got %h required %h", d, deint(f2)); end
    idle(60);
    checks++; if (outQ.size() != 0) begin fails++; $display("[TB] FAIL midrst_stale_output: got %0d extra bits required 0", outQ.size()); end
    checks++; if (frames_out !== 8'd1) begin fails++; $display("[TB] FAIL midrst_frames_out_after: got %0d required 1", frames_out); end
  endtask

`ifdef DEINT_BYPASS_EN
  task automatic test_bypass();
    logic [3:0] pat;
    pat = 4'b1101;
    doReset();
    bypass = 1'b1;
    idle(2);
    @(negedge Clk);
    in_bit = pat[0];
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++; if (out_valid !== 1'b1 || out_bit !== pat[i]) begin fails++; $display("[TB] FAIL bypass_bit%0d: got valid=%b bit=%b required valid=1 bit=%b", i, out_valid, out_bit, pat[i]); end
      checks++; if (out_sof !== (i == 0)) begin fails++; $display("[TB] FAIL bypass_sof%0d: got %b required %b", i, out_sof, (i == 0)); end
      if (i < 3) in_bit = pat[i + 1];
      else in_valid = 1'b0;
    end
    bypass = 1'b0;
    idle(3);
    checks++; if (frames_out !== 8'd0) begin fails++; $display("[TB] FAIL bypass_frames_out: got %0d required 0", frames_out); end
  endtask
`endif

  initial begin
    $display("[TB] starting block_deinterleaver bench");
    test_reset();
    test_onehot();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
`ifdef DEINT_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/block_deinterleaver.md
Name: block_deinterleaver

Overview:
Receiver-chain stage placed directly upstream of the Viterbi decoder. It accepts demodulated coded bits serially, one bit per accepted cycle. It collects them into 48-bit frames and emits each frame in de-interleaved order as a serial bit stream with a valid strobe, which drives the decoder's in/valid_in inputs. Ping-pong buffering lets one frame be written while the previous frame is read out.

Parameters:
N_ROWS, 6, rows of the interleaver matrix
N_COLS, 8, columns of the interleaver matrix; frame length F = N_ROWS*N_COLS = 48 (must be even, matches the decoder's 48-bit frame)

Ports:
Clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_bit  input  1  coded input bit
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  block can accept a bit this cycle
out_bit  output  1  de-interleaved bit, registered
out_valid  output  1  out_bit valid (feeds the decoder's valid_in)
out_sof  output  1  high with out_valid on bit 0 of each output frame
frames_out  output  8  count of completed output frames, wraps 255->0
drop_err  output  1  sticky: in_valid was seen while in_ready=0

Behaviour:
- Reset (reset=1 at an edge): both banks are marked empty and write/read pointers go to 0.
  - out_bit=0, out_valid=0, out_sof=0, frames_out=0, drop_err=0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Reset mid-frame discards all partial and full frame data; out_valid is 0 after that edge.
- Storage: two banks of F bits (bank0, bank1).
  - Write-bank and read-bank select bits both start at bank0.
  - Each bank has a full flag.
- Write side: a bit is accepted when in_valid=1 and in_ready=1.
  - It is stored at bank[wsel][wptr], and wptr increments.
  - When wptr=F-1 is accepted: wptr wraps to 0, full[wsel] is set, and wsel toggles.
  - in_ready = !full[wsel], computed combinationally from registered state.
  - in_valid=1 with in_ready=0: the bit is dropped and drop_err is set to 1 until reset.
- Read FSM states: IDLE and STREAM.
  - IDLE: if full[rsel]=1, go to STREAM with rptr=0.
  - STREAM: each cycle, out_bit <= bank[rsel][addr(rptr)] with addr(j) = (j mod N_COLS)*N_ROWS + (j div N_COLS).
    - out_valid <= 1; out_sof <= (rptr==0); rptr increments.
    - After rptr=F-1: clear full[rsel], toggle rsel, increment frames_out.
    - Then go back to IDLE; or stay in STREAM with rptr=0 if the other bank is already full, giving back-to-back frames with no gap.
  - Outside STREAM output cycles: out_valid=0, out_sof=0, and out_bit holds its last value.
- Latency: if the last bit of a frame is accepted at edge E and the reader is idle, bit 0 appears (out_valid=1) after edge E+2. The frame then streams for exactly F consecutive cycles.
- Simultaneous events:
  - A write completing into bank X and the read of bank X finishing in the same cycle cannot occur, because a bank is only written while empty.
  - The set of full[wsel] and the clear of full[rsel] on the same edge apply independently; clear-then-set order applies only if both target the same bank, which is impossible.
  - in_ready rises in the cycle after the reader clears the bank's full flag.
- Throughput: sustained 1 bit/cycle in and out without drops.

Optional Feature:
DEINT_BYPASS_EN
- Defined: adds input port bypass (1 bit). While bypass=1:
  - in_bit/in_valid are registered straight to out_bit/out_valid with 1-cycle latency; in_ready=1.
  - out_sof pulses on every F-th bypassed bit, starting with the first.
  - Banks are not written.
  - bypass is sampled only when both banks are empty and the read FSM is in IDLE; a change at any other time is ignored until those conditions hold.
- Undefined: no bypass port; always de-interleaves.

Test Plan:
- One-hot frame, input index 1 = 1 and all others 0 -> exactly output index 8 = 1; out_sof on output index 0; frames_out=1.
- One-hot input index 6 -> output index 1 = 1; one-hot input index 47 -> output index 47 = 1.
- Three frames streamed continuously at 1 bit/cycle -> 144 consecutive out_valid cycles with no gap; out_sof at cycles 0, 48 and 96 of the stream; drop_err=0; frames_out=3.
- Two frames written while the reader is artificially busy, then a third bit offered -> in_ready=0 and drop_err=1 sticky.
- Reset asserted after 20 bits of the second frame while frame 1 is streaming -> out_valid=0 after that edge; frames_out=0; a fresh 48-bit frame then decodes correctly.
- With DEINT_BYPASS_EN and bypass=1, input 1,0,1,1 -> out_bit 1,0,1,1 one cycle later with out_valid high.
